axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the address/data width (byte-lane count WIDTH/8).
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles spent in any AXI wait state.
REQ-003 ACLK  in  1  single clock; all logic on the rising edge.
REQ-004 ARESETn  in  1  reset; asynchronous assertion, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  WIDTH  transaction address.
REQ-009 cmd_wdata  in  WIDTH  write data.
REQ-010 cmd_wstrb  in  WIDTH/8  write byte strobes.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-013 rsp_rdata  out  WIDTH  read data; 0 for writes.
REQ-014 rsp_resp  out  2  AXI response code (00 OKAY, 10 SLVERR).
REQ-015 AWVALID  out  1  write address valid.
REQ-016 AWREADY  in  1  write address ready.
REQ-017 AWADDR  out  WIDTH  write address.
REQ-018 WVALID  out  1  write data valid.
REQ-019 WREADY  in  1  write data ready.
REQ-020 WDATA  out  WIDTH  write data.
REQ-021 WSTRB  out  WIDTH/8  write strobes.
REQ-022 BVALID  in  1  write response valid.
REQ-023 BREADY  out  1  write response ready.
REQ-024 BRESP  in  2  write response code.
REQ-025 ARVALID  out  1  read address valid.
REQ-026 ARREADY  in  1  read address ready.
REQ-027 ARADDR  out  WIDTH  read address.
REQ-028 RVALID  in  1  read data valid.
REQ-029 RREADY  out  1  read data ready.
REQ-030 RDATA  in  WIDTH  read data.
REQ-031 RRESP  in  2  read response code.

Function
REQ-032 SHALL implement the FSM states IDLE, WADDR, WRESP, RADDR, RDATA and DONE, with at most one transaction outstanding.
REQ-033 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, addr/wdata/wstrb/write SHALL be registered and the FSM SHALL go to WADDR (write) or RADDR (read) on the next cycle.
REQ-034 WADDR SHALL raise AWVALID and WVALID together; each SHALL drop the cycle after its own VALID&&READY; AWADDR/WDATA/WSTRB SHALL stay stable while the corresponding VALID is high; WRESP SHALL be entered once both handshakes are complete, whether same-cycle or in either order.
REQ-035 WRESP SHALL hold BREADY=1; on BVALID it SHALL capture BRESP, set rsp_rdata=0, and go to DONE.
REQ-036 RADDR SHALL hold ARVALID=1 until ARREADY, then go to RDATA; RDATA SHALL hold RREADY=1; on RVALID it SHALL capture RDATA/RRESP and go to DONE.
REQ-037 DONE SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_resp until rsp_ready, then return to IDLE; the next command SHALL be accepted no earlier than the following cycle.
REQ-038 Timeout: a counter of clog2(TIMEOUT)+1 bits SHALL clear on entry to WADDR/WRESP/RADDR/RDATA and increment each cycle spent there; when it reaches TIMEOUT-1 without completing, all AXI VALID/READY outputs SHALL drop next cycle and the FSM SHALL go to DONE with rsp_resp=2'b10, rsp_rdata=0.
REQ-039 A handshake in the same cycle as timeout expiry SHALL win; normal completion SHALL proceed.
REQ-040 BVALID/RVALID/AWREADY/WREADY/ARREADY outside their owning state SHALL be ignored; all AXI outputs SHALL be registered.
REQ-041 Latency with an always-ready slave and rsp_ready=1: read = cmd accept (cycle 0) -> ARVALID cycle 1 -> RREADY cycle 2 -> rsp_valid cycle 3 (assuming RVALID at cycle 2).

Reset
REQ-042 On ARESETn low: state SHALL be IDLE, all VALID/READY outputs and rsp_valid 0, AWADDR/WDATA/WSTRB/ARADDR/rsp_rdata/rsp_resp 0, cmd_ready 1, counter 0; an in-flight transaction SHALL be dropped with no response.

Verification
REQ-043 Write addr 0x4, data 0xA5A5A5A5, strb 0xF; slave readies same cycle, BRESP 00 -> AW/W single-cycle valid, rsp_valid with rsp_resp 00, rsp_rdata 0.
REQ-044 Write with AWREADY delayed 3 cycles after WREADY -> WVALID drops after its handshake, AWVALID holds stable, BREADY only after both.
REQ-045 Read addr 0x8; RVALID after 2 cycles with RDATA 0x12345678 -> rsp_rdata 0x12345678, rsp_resp 00; rsp_ready held low 4 cycles -> rsp_valid held.
REQ-046 Read; ARREADY never asserted, TIMEOUT=16 -> ARVALID drops, rsp_resp 10 and rsp_rdata 0 after 16 cycles; RVALID arriving in the expiry cycle -> normal completion instead.
REQ-047 ARESETn pulsed low during WRESP -> all outputs at reset values, no rsp_valid, next command executes normally.

Source files
------------

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between a single master and a single slave.
interface axi4_lite_master_if #(
  parameter int WIDTH = 32
);
  logic               AWVALID;
  logic               AWREADY;
  logic [WIDTH-1:0]   AWADDR;
  logic               WVALID;
  logic               WREADY;
  logic [WIDTH-1:0]   WDATA;
  logic [WIDTH/8-1:0] WSTRB;
  logic               BVALID;
  logic               BREADY;
  logic [1:0]         BRESP;
  logic               ARVALID;
  logic               ARREADY;
  logic [WIDTH-1:0]   ARADDR;
  logic               RVALID;
  logic               RREADY;
  logic [WIDTH-1:0]   RDATA;
  logic [1:0]         RRESP;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out,
// with a per-state wait timeout that reports SLVERR.
module axi4_lite_master #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [WIDTH-1:0]   cmd_addr,
  input  logic [WIDTH-1:0]   cmd_wdata,
  input  logic [WIDTH/8-1:0] cmd_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic [1:0]         rsp_resp,
  axi4_lite_master_if.master axi
);
  localparam int               CNT_W       = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             aw_done;
  logic             w_done;

  logic aw_hs;
  logic w_hs;
  logic expired;

  // VALIDs are only ever high in their owning state, so stray READYs elsewhere are inert.
  assign aw_hs   = axi.AWVALID && axi.AWREADY;
  assign w_hs    = axi.WVALID && axi.WREADY;
  assign expired = (cnt == CNT_LAST);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      axi.AWVALID <= 1'b0;
      axi.AWADDR  <= '0;
      axi.WVALID  <= 1'b0;
      axi.WDATA   <= '0;
      axi.WSTRB   <= '0;
      axi.BREADY  <= 1'b0;
      axi.ARVALID <= 1'b0;
      axi.ARADDR  <= '0;
      axi.RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            cnt       <= '0;
            if (cmd_write) begin
              axi.AWADDR  <= cmd_addr;
              axi.WDATA   <= cmd_wdata;
              axi.WSTRB   <= cmd_wstrb;
              axi.AWVALID <= 1'b1;
              axi.WVALID  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WADDR;
            end else begin
              axi.ARADDR  <= cmd_addr;
              axi.ARVALID <= 1'b1;
              state       <= RADDR;
            end
          end
        end

        WADDR: begin
          if (aw_hs) begin
            axi.AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          // Both channels may finish together or in either order.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            axi.BREADY <= 1'b1;
            cnt        <= '0;
            state      <= WRESP;
          end else if (expired) begin
            axi.AWVALID <= 1'b0;
            axi.WVALID  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WRESP: begin
          if (axi.BVALID) begin
            axi.BREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= axi.BRESP;
            rsp_rdata  <= '0;
            state      <= DONE;
          end else if (expired) begin
            axi.BREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= RESP_SLVERR;
            rsp_rdata  <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RADDR: begin
          if (axi.ARREADY) begin
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b1;
            cnt         <= '0;
            state       <= RDATA;
          end else if (expired) begin
            axi.ARVALID <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RDATA: begin
          if (axi.RVALID) begin
            axi.RREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= axi.RRESP;
            rsp_rdata  <= axi.RDATA;
            state      <= DONE;
          end else if (expired) begin
            axi.RREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= RESP_SLVERR;
            rsp_rdata  <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          // Response fields are frozen here; only the handshake moves us on.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master driving the AXI slave side by hand.
module tb_axi4_lite_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int errors = 0;
  int checks = 0;

  axi4_lite_master_if #(.WIDTH(32)) axi ();

  axi4_lite_master #(.WIDTH(32), .TIMEOUT(16)) dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (axi)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RDATA   = '0;
    axi.RRESP   = 2'b00;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    slave_idle();
    tick();
    tick();
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID}, 0);
    check_val("rst_readys", {axi.BREADY, axi.RREADY}, 0);
    check_val("rst_data", {axi.AWADDR, axi.ARADDR}, 0);
    check_val("rst_rsp", {rsp_rdata, rsp_resp}, 0);
    rst_n = 1'b1;
    tick();

    // Read 0x8, RVALID two cycles late, response held while rsp_ready low.
    axi.ARREADY = 1'b1;
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    check_val("rd_arvalid", axi.ARVALID, 1);
    check_val("rd_araddr", axi.ARADDR, 32'h8);
    check_val("rd_cmd_ready_busy", cmd_ready, 0);
    tick();
    axi.ARREADY = 1'b0;
    check_val("rd_arvalid_drop", axi.ARVALID, 0);
    check_val("rd_rready", axi.RREADY, 1);
    tick();
    tick();
    check_val("rd_rready_wait", axi.RREADY, 1);
    check_val("rd_no_rsp_yet", rsp_valid, 0);
    axi.RVALID = 1'b1;
    axi.RDATA  = 32'h12345678;
    tick();
    axi.RVALID = 1'b0;
    axi.RDATA  = 32'hFFFFFFFF;
    check_val("rd_rsp_valid", rsp_valid, 1);
    check_val("rd_rdata", rsp_rdata, 32'h12345678);
    check_val("rd_resp", rsp_resp, 2'b00);
    check_val("rd_rready_drop", axi.RREADY, 0);
    for (int i = 0; i < 4; i++) tick();
    check_val("rd_hold_valid", rsp_valid, 1);
    check_val("rd_hold_rdata", rsp_rdata, 32'h12345678);
    check_val("rd_hold_no_accept", cmd_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("rd_rsp_done", rsp_valid, 0);
    check_val("rd_back_idle", cmd_ready, 1);

    // Write 0x4 with a fully ready slave.
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    axi.BVALID  = 1'b1;
    issue(1'b1, 32'h4, 32'hA5A5A5A5, 4'hF);
    check_val("wr_valids", {axi.AWVALID, axi.WVALID}, 2'b11);
    check_val("wr_awaddr", axi.AWADDR, 32'h4);
    check_val("wr_wdata", axi.WDATA, 32'hA5A5A5A5);
    check_val("wr_wstrb", axi.WSTRB, 4'hF);
    check_val("wr_bready_early", axi.BREADY, 0);
    tick();
    check_val("wr_valids_drop", {axi.AWVALID, axi.WVALID}, 2'b00);
    check_val("wr_bready", axi.BREADY, 1);
    tick();
    slave_idle();
    check_val("wr_rsp_valid", rsp_valid, 1);
    check_val("wr_resp", rsp_resp, 2'b00);
    check_val("wr_rdata_zero", rsp_rdata, 0);
    check_val("wr_bready_drop", axi.BREADY, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("wr_rsp_done", rsp_valid, 0);

    // Write with AWREADY three cycles after WREADY, slave error.
    axi.WREADY = 1'b1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'h3);
    tick();
    axi.WREADY = 1'b0;
    check_val("wd_wvalid_drop", axi.WVALID, 0);
    check_val("wd_awvalid_hold1", axi.AWVALID, 1);
    check_val("wd_bready_wait1", axi.BREADY, 0);
    tick();
    tick();
    check_val("wd_awvalid_hold3", axi.AWVALID, 1);
    check_val("wd_awaddr_stable", axi.AWADDR, 32'h10);
    check_val("wd_bready_wait3", axi.BREADY, 0);
    axi.AWREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0;
    check_val("wd_awvalid_drop", axi.AWVALID, 0);
    check_val("wd_bready", axi.BREADY, 1);
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b10;
    tick();
    slave_idle();
    check_val("wd_resp_slverr", rsp_resp, 2'b10);
    check_val("wd_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Back-to-back latency with always-ready slave.
    axi.ARREADY = 1'b1;
    axi.RVALID  = 1'b1;
    axi.RDATA   = 32'hCAFEF00D;
    rsp_ready   = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    check_val("lat_c1_arvalid", axi.ARVALID, 1);
    tick();
    check_val("lat_c2_rready", axi.RREADY, 1);
    check_val("lat_c2_no_rsp", rsp_valid, 0);
    tick();
    check_val("lat_c3_rsp_valid", rsp_valid, 1);
    check_val("lat_c3_rdata", rsp_rdata, 32'hCAFEF00D);
    tick();
    check_val("lat_c4_idle", {rsp_valid, cmd_ready}, 2'b01);
    slave_idle();
    rsp_ready = 1'b0;

    // ARREADY never comes: timeout after 16 cycles of ARVALID.
    issue(1'b0, 32'hC, 32'h0, 4'h0);
    n = 0;
    while (axi.ARVALID && n < 40) begin
      n++;
      tick();
    end
    check_val("to_arvalid_cycles", n, 16);
    check_val("to_rsp_valid", rsp_valid, 1);
    check_val("to_resp", rsp_resp, 2'b10);
    check_val("to_rdata_zero", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // RVALID lands exactly in the expiry cycle of RDATA: completion wins.
    axi.ARREADY = 1'b1;
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    tick();
    axi.ARREADY = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_val("tw_rready_last", axi.RREADY, 1);
    check_val("tw_not_done", rsp_valid, 0);
    axi.RVALID = 1'b1;
    axi.RDATA  = 32'h0BADF00D;
    tick();
    slave_idle();
    check_val("tw_rsp_valid", rsp_valid, 1);
    check_val("tw_resp_ok", rsp_resp, 2'b00);
    check_val("tw_rdata", rsp_rdata, 32'h0BADF00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset pulse while waiting in WRESP drops the transaction.
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    issue(1'b1, 32'h40, 32'h11223344, 4'hF);
    tick();
    slave_idle();
    check_val("rs_in_wresp", axi.BREADY, 1);
    rst_n = 1'b0;
    #2;
    check_val("rs_bready", axi.BREADY, 0);
    check_val("rs_cmd_ready", cmd_ready, 1);
    check_val("rs_data", {axi.AWADDR, axi.WDATA}, 0);
    axi.BVALID = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    axi.BVALID = 1'b0;
    check_val("rs_no_rsp", rsp_valid, 0);
    check_val("rs_idle_ready", cmd_ready, 1);
    axi.ARREADY = 1'b1;
    axi.RVALID  = 1'b1;
    axi.RDATA   = 32'h55AA55AA;
    rsp_ready   = 1'b1;
    issue(1'b0, 32'h44, 32'h0, 4'h0);
    tick();
    tick();
    check_val("rs_next_rsp", rsp_valid, 1);
    check_val("rs_next_rdata", rsp_rdata, 32'h55AA55AA);
    slave_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
